// File: rtl/fc_layer_scheduler.sv
// fc_layer_scheduler
//   Sequences the three LeNet-5 fully-connected layers (FC1 400->120,
//   FC2 120->84, FC3 84->10) onto one shared per-neuron MAC/tanh engine.
//   It issues one neuron job at a time and waits for the engine's completion
//   pulse before it moves on, so at most one job is outstanding.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_i          synchronous active-high reset
//   start_i        begin an FC1..FC3 run (only looked at in IDLE)
//   busy_o         run in progress (ISSUE/WAIT/NEXT)
//   done_o         one-cycle pulse after the final job completes
//   job_valid_o    job fields valid; held until job_ready_i
//   job_ready_i    engine accepts the job on job_valid_o & job_ready_i
//   job_layer_o    1=FC1 2=FC2 3=FC3
//   job_neuron_o   neuron index within the layer
//   job_in_len_o   input vector length of the layer
//   job_w_base_o   first weight address of this neuron's row
//   job_b_addr_o   bias address of this neuron (0..213 over a run)
//   job_src_buf_o  input buffer  (0=A 1=B 2=C 3=D)
//   job_dst_buf_o  output buffer (same encoding)
//   job_act_en_o   1 = shift + tanh, 0 = raw shifted logit
//   mac_done_i     engine pulse: current job result written
//   layer_done_o   one-cycle pulse after the last neuron of a layer completes
//   err_o          sticky: mac_done_i seen outside WAIT
module fc_layer_scheduler #(
   parameter int FC1_IN  = 400,
   parameter int FC1_OUT = 120,
   parameter int FC2_IN  = 120,
   parameter int FC2_OUT = 84,
   parameter int FC3_IN  = 84,
   parameter int FC3_OUT = 10,
   parameter int W_AW    = 16,
   parameter int B_AW    = 8
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   output logic            busy_o,
   output logic            done_o,
   output logic            job_valid_o,
   input  logic            job_ready_i,
   output logic [1:0]      job_layer_o,
   output logic [6:0]      job_neuron_o,
   output logic [9:0]      job_in_len_o,
   output logic [W_AW-1:0] job_w_base_o,
   output logic [B_AW-1:0] job_b_addr_o,
   output logic [1:0]      job_src_buf_o,
   output logic [1:0]      job_dst_buf_o,
   output logic            job_act_en_o,
   input  logic            mac_done_i,
   output logic            layer_done_o,
   output logic            err_o
);

   // Layer base addresses, folded to constants at elaboration.
   localparam logic [W_AW-1:0] W_BASE2 = W_AW'(FC1_IN * FC1_OUT);
   localparam logic [W_AW-1:0] W_BASE3 = W_AW'(FC1_IN * FC1_OUT + FC2_IN * FC2_OUT);
   localparam logic [B_AW-1:0] B_BASE2 = B_AW'(FC1_OUT);
   localparam logic [B_AW-1:0] B_BASE3 = B_AW'(FC1_OUT + FC2_OUT);

   localparam logic [1:0] BUF_A = 2'd0;
   localparam logic [1:0] BUF_B = 2'd1;
   localparam logic [1:0] BUF_C = 2'd2;
   localparam logic [1:0] BUF_D = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_NEXT  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      layer_q, layer_d;
   logic [6:0]      neuron_q, neuron_d;
   logic [9:0]      in_len_q, in_len_d;
   logic [W_AW-1:0] w_base_q, w_base_d;
   logic [B_AW-1:0] b_addr_q, b_addr_d;
   logic [1:0]      src_q, src_d;
   logic [1:0]      dst_q, dst_d;
   logic            act_q, act_d;
   logic            err_q, err_d;

   logic [6:0]      last_neuron;
   logic            last_in_layer;
   logic            last_job;

   // Index of the final neuron of the layer currently being sequenced.
   always_comb begin
      last_neuron = 7'(FC3_OUT - 1);
      case (layer_q)
         2'd1:    last_neuron = 7'(FC1_OUT - 1);
         2'd2:    last_neuron = 7'(FC2_OUT - 1);
         default: last_neuron = 7'(FC3_OUT - 1);
      endcase
   end

   assign last_in_layer = (neuron_q == last_neuron);
   assign last_job      = last_in_layer && (layer_q == 2'd3);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         layer_q  <= '0;
         neuron_q <= '0;
         in_len_q <= '0;
         w_base_q <= '0;
         b_addr_q <= '0;
         src_q    <= '0;
         dst_q    <= '0;
         act_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         layer_q  <= layer_d;
         neuron_q <= neuron_d;
         in_len_q <= in_len_d;
         w_base_q <= w_base_d;
         b_addr_q <= b_addr_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         act_q    <= act_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      layer_d      = layer_q;
      neuron_d     = neuron_q;
      in_len_d     = in_len_q;
      w_base_d     = w_base_q;
      b_addr_d     = b_addr_q;
      src_d        = src_q;
      dst_d        = dst_q;
      act_d        = act_q;
      // A completion pulse is only meaningful while a job is outstanding.
      err_d        = err_q | (mac_done_i && (state_q != S_WAIT));

      busy_o       = 1'b0;
      done_o       = 1'b0;
      job_valid_o  = 1'b0;
      layer_done_o = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d  = S_ISSUE;
               layer_d  = 2'd1;
               neuron_d = '0;
               in_len_d = 10'(FC1_IN);
               w_base_d = '0;
               b_addr_d = '0;
               src_d    = BUF_C;
               dst_d    = BUF_B;
               act_d    = 1'b1;
            end
         end
         S_ISSUE: begin
            busy_o      = 1'b1;
            job_valid_o = 1'b1;
            if (job_ready_i) state_d = S_WAIT;
         end
         S_WAIT: begin
            busy_o = 1'b1;
            if (mac_done_i) state_d = last_job ? S_DONE : S_NEXT;
         end
         S_NEXT: begin
            busy_o       = 1'b1;
            layer_done_o = last_in_layer;
            state_d      = S_ISSUE;
            b_addr_d     = b_addr_q + 1'b1;
            if (last_in_layer) begin
               // Layer wrap: reload bases rather than accumulate, so the
               // layer map is anchored to its elaboration-time constants.
               neuron_d = '0;
               layer_d  = layer_q + 2'd1;
               if (layer_q == 2'd1) begin
                  in_len_d = 10'(FC2_IN);
                  w_base_d = W_BASE2;
                  b_addr_d = B_BASE2;
                  src_d    = BUF_B;
                  dst_d    = BUF_A;
                  act_d    = 1'b1;
               end else begin
                  in_len_d = 10'(FC3_IN);
                  w_base_d = W_BASE3;
                  b_addr_d = B_BASE3;
                  src_d    = BUF_A;
                  dst_d    = BUF_D;
                  act_d    = 1'b0;
               end
            end else begin
               neuron_d = neuron_q + 7'd1;
               w_base_d = w_base_q + W_AW'(in_len_q);
            end
         end
         S_DONE: begin
            done_o       = 1'b1;
            layer_done_o = 1'b1;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign job_layer_o   = layer_q;
   assign job_neuron_o  = neuron_q;
   assign job_in_len_o  = in_len_q;
   assign job_w_base_o  = w_base_q;
   assign job_b_addr_o  = b_addr_q;
   assign job_src_buf_o = src_q;
   assign job_dst_buf_o = dst_q;
   assign job_act_en_o  = act_q;
   assign err_o         = err_q;

endmodule

// File: tb/tb_fc_layer_scheduler.sv
module tb_fc_layer_scheduler;

   typedef struct packed {
      logic [1:0]  layer;
      logic [6:0]  neuron;
      logic [9:0]  len;
      logic [15:0] w;
      logic [7:0]  b;
      logic [1:0]  src;
      logic [1:0]  dst;
      logic        act;
   } job_t;

   logic        clk, rst, start_i, job_ready, mac_done;
   logic        busy, done, job_valid, layer_done, err;
   logic [1:0]  job_layer, job_src, job_dst;
   logic [6:0]  job_neuron;
   logic [9:0]  job_in_len;
   logic [15:0] job_w_base;
   logic [7:0]  job_b_addr;
   logic        job_act;

   fc_layer_scheduler dut (
      .clk_i(clk), .rst_i(rst), .start_i(start_i), .busy_o(busy), .done_o(done),
      .job_valid_o(job_valid), .job_ready_i(job_ready), .job_layer_o(job_layer),
      .job_neuron_o(job_neuron), .job_in_len_o(job_in_len), .job_w_base_o(job_w_base),
      .job_b_addr_o(job_b_addr), .job_src_buf_o(job_src), .job_dst_buf_o(job_dst),
      .job_act_en_o(job_act), .mac_done_i(mac_done), .layer_done_o(layer_done),
      .err_o(err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int   total = 0, bad = 0;
   job_t exp_q[$];
   int   acc_cnt = 0, ld_cnt = 0, done_cnt = 0, stall7 = 0, cyc = 0;
   bit   rand_mode = 0, bp_en = 0, force_md = 0;

   function automatic string fmt(input job_t j);
      return $sformatf("L%0d n%0d len%0d w%0d b%0d src%0d dst%0d act%0d",
                       j.layer, j.neuron, j.len, j.w, j.b, j.src, j.dst, j.act);
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
      total++;
      if (got !== expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, expv, $time);
      end
   endtask

   // Reference: the whole run as a list of jobs, straight from the layer map.
   task automatic push_run();
      int lens[3], outs[3], wb[3], src[3], dst[3], act[3];
      int idx;
      job_t e;
      lens = '{400, 120, 84};
      outs = '{120, 84, 10};
      wb   = '{0, 400 * 120, 400 * 120 + 120 * 84};
      src  = '{2, 1, 0};
      dst  = '{1, 0, 3};
      act  = '{1, 1, 0};
      idx  = 0;
      for (int l = 0; l < 3; l++) begin
         for (int n = 0; n < outs[l]; n++) begin
            e.layer  = 2'(l + 1);
            e.neuron = 7'(n);
            e.len    = 10'(lens[l]);
            e.w      = 16'(wb[l] + n * lens[l]);
            e.b      = 8'(idx);
            e.src    = 2'(src[l]);
            e.dst    = 2'(dst[l]);
            e.act    = act[l][0];
            exp_q.push_back(e);
            idx++;
         end
      end
   endtask

   // Mock engine: ready (random or always), optional 5-cycle stall on job 7,
   // mac_done a fixed 3 or random 1..5 cycles after acceptance.
   initial begin
      int  pend;
      bit  acc;
      int  bp_n;
      job_ready = 1'b0;
      mac_done  = 1'b0;
      pend = 0;
      bp_n = 0;
      forever begin
         @(negedge clk);
         acc = job_valid && job_ready && !rst;
         @(posedge clk);
         #1;
         mac_done = 1'b0;
         if (rst) begin
            pend = 0;
            bp_n = 0;
            job_ready = 1'b0;
         end else begin
            if (acc) pend = rand_mode ? int'($urandom_range(1, 5)) : 3;
            if (pend > 0) begin
               pend--;
               if (pend == 0) mac_done = 1'b1;
            end
            if (force_md) begin
               mac_done = 1'b1;
               force_md = 0;
            end
            if (acc_cnt == 0) bp_n = 0;
            if (bp_en && job_valid && acc_cnt == 7 && bp_n < 5) begin
               job_ready = 1'b0;
               bp_n++;
            end else begin
               job_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
         end
      end
   end

   // Monitor / scoreboard.
   initial begin
      int   md_cyc;
      bit   prev_valid;
      job_t got;
      md_cyc = -100;
      prev_valid = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            prev_valid = 0;
         end else begin
            if (job_valid) begin
               got = '{job_layer, job_neuron, job_in_len, job_w_base, job_b_addr,
                       job_src, job_dst, job_act};
               total++;
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("FAIL job_unexpected: got %s expected none", fmt(got));
               end else if (got !== exp_q[0]) begin
                  bad++;
                  $display("FAIL job%0d_fields: got %s expected %s", acc_cnt, fmt(got), fmt(exp_q[0]));
               end
               if (!prev_valid && acc_cnt > 0)
                  chk("mac_done_to_valid_lat", 32'(cyc - md_cyc), 32'd2);
               if (job_valid && !job_ready && acc_cnt == 7) stall7++;
               if (job_ready) begin
                  if (exp_q.size() > 0) void'(exp_q.pop_front());
                  acc_cnt++;
               end
            end
            if (layer_done) begin
               ld_cnt++;
               chk("layer_done_job", 32'((acc_cnt - 1 == 119 || acc_cnt - 1 == 203 ||
                                          acc_cnt - 1 == 213) ? 1 : 0), 32'd1);
               chk("layer_done_lat", 32'(cyc - md_cyc), 32'd1);
            end
            if (done) begin
               done_cnt++;
               chk("done_jobs", 32'(acc_cnt), 32'd214);
               chk("done_lat", 32'(cyc - md_cyc), 32'd1);
            end
            if (mac_done) md_cyc = cyc;
            prev_valid = job_valid;
         end
      end
   end

   task automatic do_run(input bit rnd, input bit bp, input bit inj, input int rst_at,
                         input bit exp_err);
      int guard;
      bit injd;
      rand_mode = rnd;
      bp_en     = bp;
      stall7    = 0;
      ld_cnt    = 0;
      done_cnt  = 0;
      acc_cnt   = 0;
      push_run();
      @(negedge clk); #1;
      start_i = 1'b1;
      @(negedge clk); #1;
      start_i = 1'b0;
      chk("start_to_valid", 32'(job_valid), 32'd1);
      chk("busy_after_start", 32'(busy), 32'd1);
      guard = 0;
      injd  = 0;
      while (done_cnt == 0 && guard < 6000) begin
         @(negedge clk); #1;
         guard++;
         start_i = 1'b0;
         if (inj && !injd && acc_cnt == 50 && job_valid) begin
            start_i = 1'b1;
            injd = 1;
         end
         if (rst_at > 0 && acc_cnt == rst_at + 1) begin
            @(negedge clk); #1;
            chk("wait_busy", 32'(busy), 32'd1);
            chk("wait_no_valid", 32'(job_valid), 32'd0);
            rst = 1'b1;
            @(negedge clk); #1;
            chk("midrst_outputs", 32'({busy, done, job_valid, layer_done, err}), 32'd0);
            chk("midrst_fields", 32'({job_layer, job_neuron, job_in_len}), 32'd0);
            chk("midrst_addr", 32'({job_w_base, job_b_addr, job_src, job_dst, job_act}), 32'd0);
            exp_q.delete();
            acc_cnt = 0;
            rst = 1'b0;
            return;
         end
      end
      start_i = 1'b0;
      if (guard >= 6000) begin
         total++;
         bad++;
         $display("FAIL run_timeout: got %0d jobs expected 214", acc_cnt);
      end
      repeat (4) @(negedge clk);
      #1;
      chk("done_count", 32'(done_cnt), 32'd1);
      chk("layer_done_count", 32'(ld_cnt), 32'd3);
      chk("jobs_accepted", 32'(acc_cnt), 32'd214);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      chk("busy_after_done", 32'(busy), 32'd0);
      chk("idle_no_valid", 32'(job_valid), 32'd0);
      chk("err_state", 32'(err), 32'(exp_err));
      if (inj) chk("start_inject_seen", 32'(injd), 32'd1);
      if (bp) chk("job7_stall_cycles", 32'(stall7), 32'd5);
   endtask

   initial begin
      rst     = 1'b1;
      start_i = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_outputs", 32'({busy, done, job_valid, layer_done, err}), 32'd0);
      chk("rst_fields", 32'({job_layer, job_neuron, job_in_len}), 32'd0);
      chk("rst_addr", 32'({job_w_base, job_b_addr, job_src, job_dst, job_act}), 32'd0);
      rst = 1'b0;

      do_run(0, 0, 0, 0, 0);    // fixed engine timing, full run
      do_run(1, 1, 1, 0, 0);    // random timing, stall on job 7, stray start
      do_run(0, 0, 0, 130, 0);  // reset while job 130 is outstanding
      do_run(1, 0, 0, 0, 0);    // restart after reset begins at FC1 n0

      // Stray completion pulse while idle.
      @(negedge clk); #1;
      force_md = 1;
      repeat (4) @(negedge clk);
      #1;
      chk("stray_err", 32'(err), 32'd1);
      chk("stray_idle_busy", 32'(busy), 32'd0);
      chk("stray_idle_valid", 32'(job_valid), 32'd0);
      do_run(1, 0, 0, 0, 1);    // err remains set through a full run

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
